// File: rtl/output_fm_drain.sv
// Drains a finished output feature-map tile from four rotating bank buffers into the output FIFO.
// Reads are issued one per cycle while a 2-entry skid buffer can still absorb the returning data.
module output_fm_drain #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned Tm = 16,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 16,
  parameter int unsigned X  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_fm_store_start,
  output logic          out_fm_store_done,
  output logic          out_fm_store_busy,
  input  logic          conv_tile_reset,
  output logic          rd_ena,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data0,
  input  logic [DW-1:0] rd_data1,
  input  logic [DW-1:0] rd_data2,
  input  logic [DW-1:0] rd_data3,
  output logic [DW-1:0] out_fm_fifo_data,
  output logic          out_fm_fifo_push,
  input  logic          out_fm_fifo_full
);

  localparam int unsigned Slice = Tr * Tc;
  localparam int unsigned Size  = Tm * Slice;
  localparam int unsigned CW    = $clog2(Size + 1);
  localparam int unsigned SW    = (Slice > 1) ? $clog2(Slice) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   pushed_q, pushed_d;
  logic [SW-1:0]   off_q, off_d;
  logic [1:0]      bank_q, bank_d;
  logic [AW-1:0]   base_q, base_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      rbank_q, rbank_d;
  logic [1:0]      occ_q, occ_d;
  logic [DW-1:0]   skid0_q, skid0_d;
  logic [DW-1:0]   skid1_q, skid1_d;

  logic            pop;
  logic            issue;
  logic [2:0]      level;
  logic [DW-1:0]   in_data;

  // Level the skid will hold next cycle before any new issue lands.
  assign pop   = (occ_q != 2'd0) && !out_fm_fifo_full;
  assign level = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == StBusy) && (issued_q < CW'(Size)) && (level < 3'd2);

  assign rd_ena            = issue;
  assign rd_addr           = issue ? (base_q + AW'(off_q)) : '0;
  assign out_fm_fifo_push  = pop;
  assign out_fm_fifo_data  = skid0_q;
  assign out_fm_store_done = (state_q == StDone);
  assign out_fm_store_busy = (state_q != StIdle);

  always_comb begin
    in_data = rd_data0;
    unique case (rbank_q)
      2'd0: in_data = rd_data0;
      2'd1: in_data = rd_data1;
      2'd2: in_data = rd_data2;
      2'd3: in_data = rd_data3;
      default: in_data = rd_data0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    pushed_d   = pushed_q;
    off_d      = off_q;
    bank_d     = bank_q;
    base_d     = base_q;
    occ_d      = occ_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    inflight_d = issue;
    rbank_d    = bank_q;

    if (state_q == StBusy) begin
      if (issue) begin
        issued_d = issued_q + CW'(1);
        if (off_q == SW'(Slice - 1)) begin
          off_d  = '0;
          bank_d = bank_q + 2'd1;
          // Wrapping from the last bank moves every bank to its next slice.
          if (bank_q == 2'(X - 1)) begin
            base_d = base_q + AW'(Slice);
          end
        end else begin
          off_d = off_q + SW'(1);
        end
      end
      if (pop) begin
        pushed_d = pushed_q + CW'(1);
      end
    end else begin
      issued_d = '0;
      pushed_d = '0;
      off_d    = '0;
      bank_d   = '0;
      base_d   = '0;
    end

    if (pop) begin
      skid0_d = skid1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) begin
        skid0_d = in_data;
      end else begin
        skid1_d = in_data;
      end
      occ_d = occ_d + 2'd1;
    end

    unique case (state_q)
      StIdle: if (out_fm_store_start) state_d = StBusy;
      StBusy: if (pushed_d == CW'(Size)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (conv_tile_reset) begin
      state_d    = StIdle;
      issued_d   = '0;
      pushed_d   = '0;
      off_d      = '0;
      bank_d     = '0;
      base_d     = '0;
      occ_d      = '0;
      skid0_d    = '0;
      skid1_d    = '0;
      inflight_d = 1'b0;
      rbank_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      pushed_q   <= '0;
      off_q      <= '0;
      bank_q     <= '0;
      base_q     <= '0;
      inflight_q <= 1'b0;
      rbank_q    <= '0;
      occ_q      <= '0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      pushed_q   <= pushed_d;
      off_q      <= off_d;
      bank_q     <= bank_d;
      base_q     <= base_d;
      inflight_q <= inflight_d;
      rbank_q    <= rbank_d;
      occ_q      <= occ_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

endmodule

// File: tb/tb_output_fm_drain.sv
// Bench for output_fm_drain: bank memories return {bank, addr}; the FIFO side is checked
// against an arithmetic model of the drain order and timing.
module tb_output_fm_drain;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TM = 8;
  localparam int unsigned TR = 2;
  localparam int unsigned TC = 2;
  localparam int SLICE = TR * TC;
  localparam int SIZE  = TM * SLICE;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ctr = 1'b0;
  logic          full = 1'b0;
  logic          done, busy, rd_ena, push;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data0 = '0, rd_data1 = '0, rd_data2 = '0, rd_data3 = '0;
  logic [DW-1:0] fifo_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] pq[$];
  int            pc[$];
  logic [AW-1:0] aq[$];
  int            ac[$];
  int            dc[$];
  int            busy_n = 0;
  int            viol = 0;

  output_fm_drain #(.AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC), .X(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .out_fm_store_start(start),
    .out_fm_store_done (done),
    .out_fm_store_busy (busy),
    .conv_tile_reset   (ctr),
    .rd_ena            (rd_ena),
    .rd_addr           (rd_addr),
    .rd_data0          (rd_data0),
    .rd_data1          (rd_data1),
    .rd_data2          (rd_data2),
    .rd_data3          (rd_data3),
    .out_fm_fifo_data  (fifo_data),
    .out_fm_fifo_push  (push),
    .out_fm_fifo_full  (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank memories: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    if (rd_ena) begin
      rd_data0 <= {16'd0, rd_addr};
      rd_data1 <= {16'd1, rd_addr};
      rd_data2 <= {16'd2, rd_addr};
      rd_data3 <= {16'd3, rd_addr};
    end else begin
      rd_data0 <= $urandom;
      rd_data1 <= $urandom;
      rd_data2 <= $urandom;
      rd_data3 <= $urandom;
    end
  end

  always @(negedge clk) begin
    if (push) begin
      pq.push_back(fifo_data);
      pc.push_back(cyc);
    end
    if (push && full) viol++;
    if (rd_ena) begin
      aq.push_back(rd_addr);
      ac.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
    if (busy) busy_n++;
  end

  function automatic int exp_addr(int k);
    return (k / SLICE / 4) * SLICE + k % SLICE;
  endfunction

  function automatic logic [DW-1:0] exp_word(int k);
    int b = (k / SLICE) % 4;
    return {16'(b), 16'(exp_addr(k))};
  endfunction

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  task automatic clear_mon();
    pq.delete(); pc.delete(); aq.delete(); ac.delete(); dc.delete();
    busy_n = 0;
    viol = 0;
  endtask

  task automatic goto_cycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && dc.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (dc.size() == 0) begin
      errors++;
      $display("FAIL %s done_timeout: got no done within %0d cycles, want one", name, budget);
    end
  endtask

  task automatic check_stream(input string name, input int n);
    int bad = -1;
    checks++;
    if (pq.size() != n) begin
      errors++;
      $display("FAIL %s push_count: got %0d want %0d", name, pq.size(), n);
    end
    for (int i = 0; i < pq.size() && i < n; i++) begin
      if (bad < 0 && pq[i] !== exp_word(i)) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s word[%0d]: got %h want %h", name, bad, pq[bad], exp_word(bad));
    end
  endtask

  task automatic check_addrs(input string name);
    int bad = -1;
    checks++;
    if (aq.size() != SIZE) begin
      errors++;
      $display("FAIL %s read_count: got %0d want %0d", name, aq.size(), SIZE);
    end
    for (int i = 0; i < aq.size() && i < SIZE; i++) begin
      if (bad < 0 && aq[i] !== AW'(exp_addr(i))) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s rd_addr[%0d]: got %0d want %0d", name, bad, aq[bad], exp_addr(bad));
    end
  endtask

  task automatic check_zero_outputs(input string name);
    logic [AW+DW+3:0] obs;
    obs = {busy, done, rd_ena, push, rd_addr, fifo_data};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s outputs: got busy=%b done=%b rd_ena=%b push=%b addr=%h data=%h want all 0",
               name, busy, done, rd_ena, push, rd_addr, fifo_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int t;
    clear_mon();
    full = 1'b0;
    pulse_start(t);
    wait_done("nominal", 100);
    goto_cycle(t + 45);
    check_stream("nominal", SIZE);
    check_addrs("nominal");
    checks++;
    if (ac.size() == 0 || ac[0] !== t + 1) begin
      errors++;
      $display("FAIL nominal first_rd: got %0d want %0d", ac.size() ? ac[0] : -1, t + 1);
    end
    checks++;
    if (pc.size() == 0 || pc[0] !== t + 3) begin
      errors++;
      $display("FAIL nominal first_push: got %0d want %0d", pc.size() ? pc[0] : -1, t + 3);
    end
    checks++;
    if (pc.size() == 0 || pc[pc.size()-1] !== t + 2 + SIZE) begin
      errors++;
      $display("FAIL nominal last_push: got %0d want %0d",
               pc.size() ? pc[pc.size()-1] : -1, t + 2 + SIZE);
    end
    checks++;
    if (dc.size() != 1 || dc[0] !== t + 3 + SIZE) begin
      errors++;
      $display("FAIL nominal done: got n=%0d cyc=%0d want n=1 cyc=%0d",
               dc.size(), dc.size() ? dc[0] : -1, t + 3 + SIZE);
    end
    checks++;
    if (busy_n !== SIZE + 3) begin
      errors++;
      $display("FAIL nominal busy_cycles: got %0d want %0d", busy_n, SIZE + 3);
    end
  endtask

  task automatic test_stall();
    int t;
    clear_mon();
    pulse_start(t);
    goto_cycle(t + 8);
    full = 1'b1;
    goto_cycle(t + 18);
    full = 1'b0;
    wait_done("stall", 200);
    goto_cycle(cyc + 5);
    checks++;
    if (count_in(pc, t + 3, t + 7) !== 5) begin
      errors++;
      $display("FAIL stall pre_push: got %0d want 5", count_in(pc, t + 3, t + 7));
    end
    checks++;
    if (count_in(pc, t + 8, t + 17) !== 0) begin
      errors++;
      $display("FAIL stall push_while_full: got %0d want 0", count_in(pc, t + 8, t + 17));
    end
    checks++;
    if (count_in(ac, t + 10, t + 17) !== 0) begin
      errors++;
      $display("FAIL stall late_reads: got %0d want 0", count_in(ac, t + 10, t + 17));
    end
    check_stream("stall", SIZE);
    checks++;
    if (dc.size() !== 1) begin
      errors++;
      $display("FAIL stall done_count: got %0d want 1", dc.size());
    end
  endtask

  task automatic test_random_full();
    int t;
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      pulse_start(t);
      for (int i = 0; i < 400 && dc.size() == 0; i++) begin
        full = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      full = 1'b0;
      wait_done("random", 50);
      goto_cycle(cyc + 5);
      check_stream("random", SIZE);
      checks++;
      if (viol !== 0) begin
        errors++;
        $display("FAIL random push_and_full: got %0d want 0", viol);
      end
      checks++;
      if (dc.size() !== 1) begin
        errors++;
        $display("FAIL random done_count: got %0d want 1", dc.size());
      end
    end
  endtask

  task automatic test_abort();
    int t;
    clear_mon();
    pulse_start(t);
    goto_cycle(t + 12);
    ctr = 1'b1;
    goto_cycle(t + 13);
    ctr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort busy_after: got %b want 0", busy);
    end
    goto_cycle(t + 40);
    check_stream("abort_partial", 10);
    checks++;
    if (count_in(ac, t + 13, t + 40) !== 0) begin
      errors++;
      $display("FAIL abort late_reads: got %0d want 0", count_in(ac, t + 13, t + 40));
    end
    checks++;
    if (dc.size() !== 0) begin
      errors++;
      $display("FAIL abort done_count: got %0d want 0", dc.size());
    end
    // Abort wins over a simultaneous start.
    clear_mon();
    start = 1'b1;
    ctr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ctr = 1'b0;
    goto_cycle(cyc + 5);
    checks++;
    if (busy_n !== 0 || aq.size() !== 0) begin
      errors++;
      $display("FAIL abort_priority: got busy_cycles=%0d reads=%0d want 0 0", busy_n, aq.size());
    end
    clear_mon();
    pulse_start(t);
    wait_done("abort_restart", 100);
    goto_cycle(cyc + 5);
    check_stream("abort_restart", SIZE);
    check_addrs("abort_restart");
  endtask

  task automatic test_restart_ignored();
    int t;
    clear_mon();
    pulse_start(t);
    goto_cycle(t + 10);
    start = 1'b1;
    goto_cycle(t + 11);
    start = 1'b0;
    goto_cycle(t + 3 + SIZE);
    start = 1'b1;
    goto_cycle(t + 4 + SIZE);
    start = 1'b0;
    goto_cycle(t + 70);
    checks++;
    if (dc.size() != 1 || dc[0] !== t + 3 + SIZE) begin
      errors++;
      $display("FAIL restart done: got n=%0d cyc=%0d want n=1 cyc=%0d",
               dc.size(), dc.size() ? dc[0] : -1, t + 3 + SIZE);
    end
    check_stream("restart", SIZE);
    checks++;
    if (busy_n !== SIZE + 3) begin
      errors++;
      $display("FAIL restart busy_cycles: got %0d want %0d", busy_n, SIZE + 3);
    end
  endtask

  task automatic test_async_reset();
    int t;
    clear_mon();
    pulse_start(t);
    goto_cycle(t + 10);
    rst = 1'b0;
    #2;
    check_zero_outputs("async_reset");
    goto_cycle(cyc + 3);
    rst = 1'b1;
    clear_mon();
    goto_cycle(cyc + 12);
    checks++;
    if (busy_n !== 0 || pq.size() !== 0 || aq.size() !== 0) begin
      errors++;
      $display("FAIL async_reset idle: got busy=%0d pushes=%0d reads=%0d want 0 0 0",
               busy_n, pq.size(), aq.size());
    end
    clear_mon();
    pulse_start(t);
    wait_done("async_restart", 100);
    goto_cycle(cyc + 5);
    check_stream("async_restart", SIZE);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_random_full();
    test_abort();
    test_restart_ignored();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
